load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: max ACCESS cycles waiting for mem_ready before abort (legal range 2..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  core presents a memory operation.
REQ-005 SHALL have ports data_r, data_w  input  1 each  load / store select (decoder outputs).
REQ-006 SHALL have port data_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-007 SHALL have port unsigned_value  input  1  zero-extend loads when 1, sign-extend when 0.
REQ-008 SHALL have ports addr, wdata  input  32 each  byte address and store data (ALU result and rs2).
REQ-009 SHALL have ports busy, done, err  output  1 each  operation in progress / one-cycle completion pulse / one-cycle error flag qualified by done.
REQ-010 SHALL have port rdata  output  32  extended load result.
REQ-011 SHALL have ports mem_req, mem_we  output  1 each; mem_addr, mem_wdata  output  32 each; mem_wstrb  output  4.
REQ-012 SHALL have ports mem_ready  input  1; mem_rdata  input  32  word-aligned memory response.

Function
REQ-013 SHALL implement FSM IDLE, ACCESS, DONE, ERR; busy=1 in every state except IDLE.
REQ-014 In IDLE, req_valid with exactly one of data_r/data_w SHALL be accepted; both or neither SHALL be ignored (stay IDLE, no pulse).
REQ-015 On accept, addr, wdata, data_size, unsigned_value, data_w SHALL be registered; inputs SHALL be ignored thereafter until IDLE.
REQ-016 Misaligned (size 01 with addr[0]=1; size 10 with addr[1:0]!=0; size 11 any) SHALL go IDLE->ERR with no mem_req; otherwise IDLE->ACCESS.
REQ-017 In ACCESS, mem_req=1, mem_we=captured data_w, mem_addr={addr[31:2],2'b00}, held stable until mem_ready sampled high.
REQ-018 Store strobes: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111; loads drive mem_wstrb=0.
REQ-019 Store data SHALL be replicated: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
REQ-020 Load data SHALL select byte lane addr[1:0] or half lane addr[1] of mem_rdata, then extend to 32 bits per unsigned_value; word passes unchanged.
REQ-021 ACCESS with mem_ready=1 SHALL register rdata (loads only) and go to DONE; stores leave rdata unchanged.
REQ-022 Timeout counter SHALL clear on entry to ACCESS, increment each ACCESS cycle with mem_ready=0; at TIMEOUT cycles without ready go to ERR.
REQ-023 mem_ready in the same cycle as timeout expiry SHALL win (normal completion).
REQ-024 DONE SHALL assert done=1, err=0 for exactly one cycle, then IDLE; ERR SHALL assert done=1, err=1, rdata=0 for one cycle, then IDLE.
REQ-025 Latency, aligned op with mem_ready immediate: req_valid cycle N, mem_req cycle N+1, done cycle N+2, new request accepted cycle N+3.
REQ-026 mem_ready outside ACCESS SHALL be ignored; req_valid while busy SHALL be ignored, not queued.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, err=0, mem_req=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, rdata=0, counter=0, including mid-ACCESS.
REQ-028 After rst_n rises, first accept SHALL occur no earlier than the first rising clk edge with rst_n=1.

Verification
REQ-029 Load byte signed: addr=0x103, size 00, unsigned 0, mem_rdata=0x80FF_FFFF, ready immediate -> mem_addr=0x100, rdata=0xFFFF_FF80, done at N+2.
REQ-030 Store half: addr=0x202, size 01, wdata=0x1234_ABCD -> mem_we=1, wstrb=4'b1100, mem_wdata=0xABCD_ABCD, rdata unchanged.
REQ-031 Misaligned word load addr=0x101 -> mem_req never high, done=1 and err=1 at N+1, rdata=0.
REQ-032 Load word with mem_ready low for TIMEOUT=16 cycles -> mem_req high 16 cycles, then done=1, err=1; ready on 16th cycle instead -> normal done, err=0.
REQ-033 rst_n low during ACCESS -> mem_req and busy drop same cycle without clk; subsequent LHU addr=0x2, mem_rdata=0x8001_0000 -> rdata=0x0000_8001.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory operation from the core, checks its
// alignment, runs a single word-aligned memory access with byte strobes and
// store-data replication, extends load data, and reports completion with a
// one-cycle done pulse (err qualified by done).
//
// Handshake: the core request is a level (req_valid with exactly one of
// data_r/data_w) sampled only while idle; it is consumed on the rising edge
// where it is accepted and ignored at all other times, so nothing is queued.
// On the memory side mem_req and all mem_* fields are held stable from the
// first ACCESS cycle until mem_ready is sampled high on a rising edge; that
// edge completes the transfer. mem_ready outside ACCESS has no effect.
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        data_r,
    input  logic        data_w,
    input  logic [1:0]  data_size,
    input  logic        unsigned_value,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2,
        ST_ERR    = 2'd3
    } state_t;

    // Last ACCESS cycle index before the wait is abandoned.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q;
    state_t      state_d;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        we_q;
    logic [31:0] rdata_q;
    logic [7:0]  cnt_q;

    logic        accept;
    logic        misaligned;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_ext;
    logic [3:0]  store_strb;
    logic [31:0] store_data;

    // A request is only meaningful when it is unambiguously a load or a store.
    assign accept = req_valid & (data_r ^ data_w);

    // Alignment check on the live request inputs, used at acceptance.
    always_comb begin
        misaligned = 1'b0;
        case (data_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = (addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    // Pick the addressed lane of the returned word and extend it to 32 bits.
    always_comb begin
        load_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        load_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            2'b00:   load_ext = uns_q ? {24'd0, load_byte} : {{24{load_byte[7]}}, load_byte};
            2'b01:   load_ext = uns_q ? {16'd0, load_half} : {{16{load_half[15]}}, load_half};
            default: load_ext = mem_rdata;
        endcase
    end

    // Byte strobes and lane-replicated store data from the captured request.
    always_comb begin
        case (size_q)
            2'b00: begin
                store_strb = 4'b0001 << addr_q[1:0];
                store_data = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                store_strb = 4'b0011 << addr_q[1:0];
                store_data = {2{wdata_q[15:0]}};
            end
            default: begin
                store_strb = 4'b1111;
                store_data = wdata_q;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: misaligned requests never touch memory; a late
    // mem_ready on the final allowed cycle still completes normally.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = misaligned ? ST_ERR : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (mem_ready) begin
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_ERR;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture the request fields once, at acceptance; held until back in idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            we_q    <= 1'b0;
        end else if (state_q == ST_IDLE && accept) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            size_q  <= data_size;
            uns_q   <= unsigned_value;
            we_q    <= data_w;
        end
    end

    // Wait counter: zero outside ACCESS, counts ACCESS cycles without ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else if (state_q != ST_ACCESS) begin
            cnt_q <= 8'd0;
        end else if (!mem_ready) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    // Load result register; stores and errors leave it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= 32'd0;
        end else if (state_q == ST_ACCESS && mem_ready && !we_q) begin
            rdata_q <= load_ext;
        end
    end

    // State-decoded outputs; the memory bus is quiet outside ACCESS.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        rdata     = rdata_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_wstrb = 4'd0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_ACCESS: begin
                busy     = 1'b1;
                mem_req  = 1'b1;
                mem_we   = we_q;
                mem_addr = {addr_q[31:2], 2'b00};
                if (we_q) begin
                    mem_wdata = store_data;
                    mem_wstrb = store_strb;
                end
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            ST_ERR: begin
                busy  = 1'b1;
                done  = 1'b1;
                err   = 1'b1;
                rdata = 32'd0;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios followed by random operations,
// each checked against a byte-lane arithmetic model of the unit's behaviour.
module tb_load_store_unit;

    localparam int TO = 16;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        data_r;
    logic        data_w;
    logic [1:0]  data_size;
    logic        unsigned_value;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int          n_checks;
    int          n_pass;
    logic [31:0] model_rdata;
    logic [31:0] exp_q[$];

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .data_r         (data_r),
        .data_w         (data_w),
        .data_size      (data_size),
        .unsigned_value (unsigned_value),
        .addr           (addr),
        .wdata          (wdata),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .rdata          (rdata),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wstrb      (mem_wstrb),
        .mem_ready      (mem_ready),
        .mem_rdata      (mem_rdata)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Random values on every core input; the unit must not react while busy.
    task automatic scramble();
        req_valid      = 1'($urandom);
        data_r         = 1'($urandom);
        data_w         = 1'($urandom);
        data_size      = 2'($urandom);
        unsigned_value = 1'($urandom);
        addr           = $urandom;
        wdata          = $urandom;
    endtask

    // Model: expected load value from byte-lane arithmetic.
    function automatic logic [31:0] model_load(input logic [31:0] word, input int bytes,
                                               input int lane, input bit uns);
        longint unsigned raw;
        longint unsigned mask;
        if (bytes == 4) return word;
        raw  = longint'(word) >> (8 * lane);
        mask = (64'd1 << (8 * bytes)) - 1;
        raw  = raw & mask;
        if (!uns && (((raw >> (8 * bytes - 1)) & 1) == 1)) raw = raw | ~mask;
        return raw[31:0];
    endfunction

    // Model: byte i of the bus carries byte (i mod size) of the store data.
    function automatic logic [31:0] model_wdata(input logic [31:0] wd, input int bytes);
        logic [31:0] r;
        r = 32'd0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % bytes) +: 8];
        return r;
    endfunction

    // Driver task: issue at the current negedge (unit idle), follow through to idle.
    // delay = number of ACCESS cycles before mem_ready; delay >= TO never answers.
    task automatic run_op(input bit is_load, input logic [1:0] size, input bit uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int delay, input logic [31:0] mword);
        int          bytes;
        int          lane;
        bit          mis;
        bit          timed_out;
        logic [31:0] e_strb;
        logic [31:0] got;
        bytes  = 1 << size;
        lane   = int'(a % 4);
        mis    = (size == 2'd3) || ((a % bytes) != 0);
        e_strb = is_load ? 32'd0 : (((32'd1 << bytes) - 1) << lane);
        timed_out = 1'b0;

        req_valid = 1'b1; data_r = is_load; data_w = !is_load;
        data_size = size; unsigned_value = uns; addr = a; wdata = wd;
        @(negedge clk);
        scramble();
        mem_ready = 1'b0;

        if (mis) begin
            check("mis_mem_req", 32'(mem_req), 32'd0);
            check("mis_done", 32'(done), 32'd1);
            check("mis_err", 32'(err), 32'd1);
            check("mis_rdata", rdata, 32'd0);
        end else begin
            if (is_load && delay < TO) exp_q.push_back(model_load(mword, bytes, lane, uns));
            for (int k = 0; k < TO; k++) begin
                check("acc_mem_req", 32'(mem_req), 32'd1);
                check("acc_done", 32'(done), 32'd0);
                check("acc_addr", mem_addr, a & 32'hFFFF_FFFC);
                check("acc_we", 32'(mem_we), 32'(!is_load));
                check("acc_wstrb", 32'(mem_wstrb), e_strb);
                if (!is_load) check("acc_wdata", mem_wdata, model_wdata(wd, bytes));
                mem_ready = (k == delay);
                mem_rdata = (k == delay) ? mword : $urandom;
                @(negedge clk);
                scramble();
                if (k == delay) break;
                if (k == TO - 1) timed_out = 1'b1;
                mem_ready = 1'($urandom);
            end
            mem_ready = 1'($urandom);
            check("end_mem_req", 32'(mem_req), 32'd0);
            check("end_done", 32'(done), 32'd1);
            check("end_err", 32'(err), 32'(timed_out));
            if (timed_out) begin
                check("end_rdata_err", rdata, 32'd0);
            end else begin
                if (is_load) begin
                    got = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                    model_rdata = got;
                end
                check("end_rdata", rdata, model_rdata);
            end
        end
        check("end_busy", 32'(busy), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        mem_ready = 1'b0;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("idle_rdata", rdata, model_rdata);
    endtask

    initial begin
        bit          ld;
        logic [1:0]  sz;
        logic [31:0] a;
        int          dly;
        n_checks = 0; n_pass = 0; model_rdata = 32'd0;
        rst_n = 1'b0; req_valid = 1'b0; data_r = 1'b0; data_w = 1'b0;
        data_size = 2'd0; unsigned_value = 1'b0; addr = 32'd0; wdata = 32'd0;
        mem_ready = 1'b0; mem_rdata = 32'd0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // both / neither select: ignored
        req_valid = 1'b1; data_r = 1'b1; data_w = 1'b1; addr = 32'h40; data_size = 2'd2;
        @(negedge clk);
        check("both_busy", 32'(busy), 32'd0);
        check("both_mem_req", 32'(mem_req), 32'd0);
        data_r = 1'b0; data_w = 1'b0;
        @(negedge clk);
        check("neither_busy", 32'(busy), 32'd0);
        check("neither_done", 32'(done), 32'd0);
        req_valid = 1'b0;

        // signed byte load, store half, misaligned word load
        run_op(1'b1, 2'd0, 1'b0, 32'h103, 32'h0, 0, 32'h80FF_FFFF);
        check("lb_rdata", rdata, 32'hFFFF_FF80);
        run_op(1'b0, 2'd1, 1'b0, 32'h202, 32'h1234_ABCD, 0, 32'h0);
        check("sh_rdata_kept", rdata, 32'hFFFF_FF80);
        run_op(1'b1, 2'd2, 1'b0, 32'h101, 32'h0, 0, 32'h0);
        // timeout, then ready on the last allowed cycle
        run_op(1'b1, 2'd2, 1'b0, 32'h300, 32'h0, TO, 32'h5555_AAAA);
        run_op(1'b1, 2'd2, 1'b0, 32'h300, 32'h0, TO - 1, 32'h5555_AAAA);
        check("lw_late_rdata", rdata, 32'h5555_AAAA);

        // asynchronous reset in the middle of ACCESS
        req_valid = 1'b1; data_r = 1'b1; data_w = 1'b0; data_size = 2'd2;
        addr = 32'h400; mem_ready = 1'b0;
        @(negedge clk);
        check("ar_mem_req_before", 32'(mem_req), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("ar_mem_req", 32'(mem_req), 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_mem_addr", mem_addr, 32'd0);
        check("ar_rdata", rdata, 32'd0);
        @(negedge clk);
        check("ar_busy_held", 32'(busy), 32'd0);
        req_valid = 1'b0;
        rst_n = 1'b1;
        model_rdata = 32'd0;
        exp_q.delete();
        @(negedge clk);
        run_op(1'b1, 2'd1, 1'b1, 32'h2, 32'h0, 0, 32'h8001_0000);
        check("lhu_rdata", rdata, 32'h0000_8001);

        // random operations
        for (int n = 0; n < 40; n++) begin
            ld  = 1'($urandom);
            sz  = 2'($urandom_range(0, 3));
            a   = $urandom;
            if ($urandom_range(0, 4) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 1);
            dly = ($urandom_range(0, 9) == 0) ? TO : int'($urandom_range(0, 3));
            run_op(ld, sz, 1'($urandom), a, $urandom, dly, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
